prog_loader: RTL



---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader_word_asm.sv | 47 ++++
 rtl/prog_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: state encodings, frame marker and
// the instruction-memory base address (must equal the core's PC reset value).
package prog_loader_pkg;

  localparam logic [31:0] LD_BASE_ADDR   = 32'h0000_1000;
  localparam int unsigned LD_DEPTH_WORDS = 1024;
  localparam logic [7:0]  LD_MAGIC       = 8'hA5;
  localparam int unsigned LD_CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Running frame checksum: plain XOR over the length and data bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid pulses
// the cycle after the fourth byte of each word.
module prog_loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        strobe,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        lane_last
);

  logic [1:0]  lane_r;
  logic [23:0] shift_r;
  logic        word_valid_r;
  logic [31:0] word_r;

  // Lane counter, byte shift register and the registered word/strobe pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_r       <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
      word_r       <= 32'd0;
    end else if (clr) begin
      lane_r       <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (strobe) begin
        shift_r <= {byte_in, shift_r[23:8]};
        lane_r  <= lane_r + 2'd1;
        if (lane_r == 2'd3) begin
          word_valid_r <= 1'b1;
          word_r       <= {byte_in, shift_r};
        end
      end
    end
  end

  assign word_valid = word_valid_r;
  assign word       = word_r;
  assign lane_last  = (lane_r == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses MAGIC/LEN/DATA/CSUM frames, writes the
// instruction memory and holds the core in reset until a verified image is in.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = LD_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = LD_DEPTH_WORDS,
  parameter logic [7:0]  MAGIC       = LD_MAGIC,
  parameter int unsigned CNT_W       = LD_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam int unsigned      PAD_W   = 32 - CNT_W - 2;

  state_t            state_r, state_next_s;
  logic              hs_s, is_magic_s, frame_start_s, data_hs_s, lane_last_s;
  logic [CNT_W-1:0]  len_r, len_s, word_idx_r;
  logic [7:0]        csum_r;
  logic [31:0]       addr_r;
  logic              rx_ready_r, cpu_rst_r, busy_r, done_r, err_r;

  assign hs_s          = rx_valid & rx_ready_r;
  assign is_magic_s    = (rx_data == MAGIC);
  assign len_s         = CNT_W'({rx_data, len_r[7:0]});
  assign data_hs_s     = hs_s && (state_r == ST_DATA);
  assign frame_start_s = hs_s && is_magic_s &&
                         ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));

  prog_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (frame_start_s),
    .byte_in    (rx_data),
    .strobe     (data_hs_s),
    .word_valid (imem_we),
    .word       (imem_wdata),
    .lane_last  (lane_last_s)
  );

  // Next-state decode; every branch holds state unless a byte is consumed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (frame_start_s) state_next_s = ST_LEN_LO;
        else               state_next_s = state_r;
      end
      ST_LEN_LO: begin
        if (hs_s) state_next_s = ST_LEN_HI;
        else      state_next_s = state_r;
      end
      ST_LEN_HI: begin
        if (!hs_s)                    state_next_s = state_r;
        else if (len_s > DEPTH_C)     state_next_s = ST_ERR;
        else if (len_s == '0)         state_next_s = ST_CSUM;
        else                          state_next_s = ST_DATA;
      end
      ST_DATA: begin
        if (data_hs_s && lane_last_s && (word_idx_r == (len_r - ONE_C))) state_next_s = ST_CSUM;
        else                                                            state_next_s = state_r;
      end
      ST_CSUM: begin
        if (!hs_s)                     state_next_s = state_r;
        else if (rx_data == csum_r)    state_next_s = ST_DONE;
        else                           state_next_s = ST_ERR;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and status flags, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rx_ready_r <= 1'b0;
      cpu_rst_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      rx_ready_r <= 1'b1;
      cpu_rst_r  <= (state_next_s != ST_DONE);
      busy_r     <= (state_next_s == ST_LEN_LO) || (state_next_s == ST_LEN_HI) ||
                    (state_next_s == ST_DATA)   || (state_next_s == ST_CSUM);
      done_r     <= (state_next_s == ST_DONE);
      err_r      <= (state_next_s == ST_ERR);
    end
  end

  // Frame datapath: length capture, checksum, word index and write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r      <= '0;
      csum_r     <= 8'd0;
      word_idx_r <= '0;
      addr_r     <= BASE_ADDR;
    end else if (frame_start_s) begin
      len_r      <= '0;
      csum_r     <= 8'd0;
      word_idx_r <= '0;
    end else if (hs_s) begin
      case (state_r)
        ST_LEN_LO: begin
          len_r[7:0] <= rx_data;
          csum_r     <= csum_next(csum_r, rx_data);
        end
        ST_LEN_HI: begin
          len_r  <= len_s;
          csum_r <= csum_next(csum_r, rx_data);
        end
        ST_DATA: begin
          csum_r <= csum_next(csum_r, rx_data);
          if (lane_last_s) begin
            addr_r     <= BASE_ADDR + {{PAD_W{1'b0}}, word_idx_r, 2'b00};
            word_idx_r <= word_idx_r + ONE_C;
          end
        end
        default: begin
          csum_r <= csum_r;
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_r;
  assign imem_addr = addr_r;
  assign cpu_rst   = cpu_rst_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
